// File: rtl/mem_trace_pkg.sv
// Shared constants and width helpers for the memory write tracer.
package mem_trace_pkg;

  localparam logic [17:0] HEX_BASE = 18'h10000;
  localparam logic [17:0] HEX_MASK = 18'h3FFFF;
  localparam logic [17:0] PIO_BASE = 18'h20000;
  localparam logic [17:0] PIO_MASK = 18'h3FFF0;

  // A single window still needs a one-bit index port.
  function automatic int win_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Occupancy must be able to represent 0..d inclusive.
  function automatic int fifo_lvl_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head, flush, and
// simultaneous push/pop accepted while full.
module trace_fifo
  import mem_trace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = fifo_lvl_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Head is read combinationally so valid and data appear on the same cycle.
  assign data_out = mem[rd_ptr_reg];
  assign level    = level_reg;

endmodule

// File: rtl/mem_write_tracer.sv
// Passive Avalon-MM write snooper: window match, hit counters, trace FIFO.
// Optional capture timestamps are enabled with MEM_WRITE_TRACER_TIMESTAMP_EN.
module mem_write_tracer
  import mem_trace_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WORD_SHIFT  = 2,
  parameter int NUM_WINDOWS = 2,
  parameter logic [NUM_WINDOWS*(ADDR_WIDTH+WORD_SHIFT)-1:0] WINDOW_BASE = {PIO_BASE, HEX_BASE},
  parameter logic [NUM_WINDOWS*(ADDR_WIDTH+WORD_SHIFT)-1:0] WINDOW_MASK = {PIO_MASK, HEX_MASK},
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16,
  parameter int TS_WIDTH    = 32,
  localparam int BA_W  = ADDR_WIDTH + WORD_SHIFT,
  localparam int BE_W  = DATA_WIDTH / 8,
  localparam int WIN_W = win_idx_width(NUM_WINDOWS),
  localparam int LVL_W = fifo_lvl_width(FIFO_DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic [BE_W-1:0]                byteenable,
  input  logic                           write,
  input  logic [DATA_WIDTH-1:0]          writedata,
  input  logic                           waitrequest,
  input  logic                           clear,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic [WIN_W-1:0]               trace_window,
  output logic [BA_W-1:0]                trace_address,
  output logic [DATA_WIDTH-1:0]          trace_data,
  output logic [BE_W-1:0]                trace_byteenable,
  output logic [TS_WIDTH-1:0]            trace_timestamp,
  output logic [NUM_WINDOWS*COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0]         dropped_count,
  output logic                           overflow,
  output logic [LVL_W-1:0]               fill_level
);

  localparam int PAYLOAD_W = WIN_W + BA_W + DATA_WIDTH + BE_W;

  logic [BA_W-1:0]        ba;
  logic [NUM_WINDOWS-1:0] match;
  logic [WIN_W-1:0]       win_sel;
  logic                   win_hit;
  logic                   capture;
  logic                   hit;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [COUNT_WIDTH-1:0] dropped_count_reg;
  logic                   overflow_reg;
  logic [PAYLOAD_W-1:0]   payload;

  assign ba      = BA_W'(address) << WORD_SHIFT;
  assign capture = write && !waitrequest;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WINDOWS; gi++) begin : g_win
      localparam logic [BA_W-1:0] BASE = WINDOW_BASE[gi*BA_W +: BA_W];
      localparam logic [BA_W-1:0] MASK = WINDOW_MASK[gi*BA_W +: BA_W];
      logic [COUNT_WIDTH-1:0] hit_count_reg;

      assign match[gi] = ((ba & MASK) == (BASE & MASK));

      always_ff @(posedge clock) begin
        if (!reset || clear) begin
          hit_count_reg <= '0;
        end else if (hit && (win_sel == WIN_W'(gi)) && !(&hit_count_reg)) begin
          hit_count_reg <= hit_count_reg + COUNT_WIDTH'(1);
        end
      end

      assign hit_count[gi*COUNT_WIDTH +: COUNT_WIDTH] = hit_count_reg;
    end
  endgenerate

  // Scan downwards so the lowest matching window index is the one kept.
  always_comb begin
    win_sel = '0;
    win_hit = 1'b0;
    for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
      if (match[i]) begin
        win_sel = WIN_W'(i);
        win_hit = 1'b1;
      end
    end
  end

  assign hit = capture && win_hit;
  // When full the head is valid, so trace_ready alone decides whether a slot frees.
  assign drop = hit && fifo_full && !trace_ready;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      dropped_count_reg <= '0;
      overflow_reg      <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (!(&dropped_count_reg)) begin
        dropped_count_reg <= dropped_count_reg + COUNT_WIDTH'(1);
      end
    end
  end

`ifdef MEM_WRITE_TRACER_TIMESTAMP_EN
  localparam int ENTRY_W = PAYLOAD_W + TS_WIDTH;
  logic [TS_WIDTH-1:0] ts_reg;

  // Free-running; clear deliberately leaves it alone so traces stay comparable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + TS_WIDTH'(1);
    end
  end
`else
  localparam int ENTRY_W = PAYLOAD_W;
`endif

  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] entry_out;

`ifdef MEM_WRITE_TRACER_TIMESTAMP_EN
  assign entry_in        = {win_sel, ba, writedata, byteenable, ts_reg};
  assign trace_timestamp = trace_valid ? entry_out[TS_WIDTH-1:0] : '0;
`else
  assign entry_in        = {win_sel, ba, writedata, byteenable};
  assign trace_timestamp = '0;
`endif

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (clear),
    .push     (hit),
    .data_in  (entry_in),
    .pop      (trace_ready),
    .data_out (entry_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fill_level)
  );

  assign trace_valid = !fifo_empty;

  // Head fields read as zero when empty, hiding stale or uninitialised RAM.
  assign payload          = trace_valid ? entry_out[ENTRY_W-1 -: PAYLOAD_W] : '0;
  assign trace_window     = payload[PAYLOAD_W-1 -: WIN_W];
  assign trace_address    = payload[BE_W+DATA_WIDTH +: BA_W];
  assign trace_data       = payload[BE_W +: DATA_WIDTH];
  assign trace_byteenable = payload[BE_W-1:0];

  assign dropped_count = dropped_count_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_mem_write_tracer.sv
// Scoreboard bench for mem_write_tracer: directed cases followed by random traffic.
module tb_mem_write_tracer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address = '0;
  logic [1:0]  byteenable = '0;
  logic        write = 1'b0;
  logic [15:0] writedata = '0;
  logic        waitrequest = 1'b0;
  logic        clear = 1'b0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [0:0]  trace_window;
  logic [17:0] trace_address;
  logic [15:0] trace_data;
  logic [1:0]  trace_byteenable;
  logic [31:0] trace_timestamp;
  logic [31:0] hit_count;
  logic [15:0] dropped_count;
  logic        overflow;
  logic [3:0]  fill_level;

  mem_write_tracer dut (
    .clock            (clock),
    .reset            (reset),
    .address          (address),
    .byteenable       (byteenable),
    .write            (write),
    .writedata        (writedata),
    .waitrequest      (waitrequest),
    .clear            (clear),
    .trace_valid      (trace_valid),
    .trace_ready      (trace_ready),
    .trace_window     (trace_window),
    .trace_address    (trace_address),
    .trace_data       (trace_data),
    .trace_byteenable (trace_byteenable),
    .trace_timestamp  (trace_timestamp),
    .hit_count        (hit_count),
    .dropped_count    (dropped_count),
    .overflow         (overflow),
    .fill_level       (fill_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [0:0]  win;
    logic [17:0] ba;
    logic [15:0] data;
    logic [1:0]  be;
    logic [31:0] ts;
  } entry_t;

  entry_t      sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          model_level = 0;
  logic [15:0] hits [2];
  logic [15:0] drops = '0;
  logic        ovf = 1'b0;
  int unsigned cyc = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference address map: the HEX word and the 16-byte PIO block.
  function automatic int win_of(input logic [17:0] ba);
    if (ba == 18'h10000) return 0;
    if (ba >= 18'h20000 && ba <= 18'h2000F) return 1;
    return -1;
  endfunction

  task automatic check_state();
    chk("trace_valid", trace_valid, model_level > 0);
    chk("fill_level", fill_level, model_level);
    chk("hit_count", hit_count, {hits[1], hits[0]});
    chk("dropped_count", dropped_count, drops);
    chk("overflow", overflow, ovf);
  endtask

  // Drive one cycle of inputs and advance the model by the edge that samples them.
  task automatic step(input logic wr, input logic [15:0] addr, input logic [15:0] dat,
                      input logic [1:0] be, input logic wt, input logic rdy, input logic clr);
    entry_t e;
    int     w;
    bit     pop;
    check_state();
    write = wr; address = addr; writedata = dat; byteenable = be;
    waitrequest = wt; trace_ready = rdy; clear = clr;
    pop = rdy && (model_level > 0);
    if (clr) begin
      sb.delete();
      model_level = 0;
      hits[0] = '0; hits[1] = '0;
      drops = '0;
      ovf = 1'b0;
    end else begin
      w = win_of({addr, 2'b00});
      if (wr && !wt && w >= 0) begin
        if (hits[w] != 16'hFFFF) hits[w] = hits[w] + 16'd1;
        if (model_level == 8 && !pop) begin
          if (drops != 16'hFFFF) drops = drops + 16'd1;
          ovf = 1'b1;
        end else begin
          e.win  = 1'(w);
          e.ba   = {addr, 2'b00};
          e.data = dat;
          e.be   = be;
`ifdef MEM_WRITE_TRACER_TIMESTAMP_EN
          e.ts   = cyc;
`else
          e.ts   = '0;
`endif
          sb.push_back(e);
          model_level++;
        end
      end
      if (pop) model_level--;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && model_level > 0; k++) idle(1'b1);
    idle(1'b0);
  endtask

  // Monitor: compares the FIFO head with the scoreboard on every handshake or stall.
  initial begin
    entry_t e;
    forever begin
      @(negedge clock);
      if (reset && !clear && trace_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_entry", {trace_window, trace_address, trace_data}, '0);
        end else if (trace_ready) begin
          e = sb.pop_front();
          chk("entry", {trace_window, trace_address, trace_data, trace_byteenable, trace_timestamp},
              {e.win, e.ba, e.data, e.be, e.ts});
          $display("pop win=%0d addr=%05h data=%04h be=%b ts=%0d",
                   trace_window, trace_address, trace_data, trace_byteenable, trace_timestamp);
        end else begin
          e = sb[0];
          chk("stalled_head", {trace_window, trace_address, trace_data, trace_byteenable, trace_timestamp},
              {e.win, e.ba, e.data, e.be, e.ts});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [15:0] a;
    hits[0] = '0; hits[1] = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_valid", trace_valid, 1'b0);
    chk("reset_fill", fill_level, 4'd0);
    chk("reset_hits", hit_count, 32'd0);
    chk("reset_dropped", dropped_count, 16'd0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_head", {trace_address, trace_data, trace_timestamp}, '0);
    reset = 1'b1;

    // Single HEX write, visible one cycle later.
    step(1'b1, 16'h4000, 16'hBEEF, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // Write held off by waitrequest is captured exactly once.
    repeat (3) step(1'b1, 16'h8003, 16'h1234, 2'b10, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h8003, 16'h1234, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // Overfill: ten PIO writes into an eight-entry FIFO.
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'h8000 | 16'(i % 4), 16'h1000 + 16'(i), 2'b11, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 8; i++)
      step(1'b1, 16'h8001, 16'h2000 + 16'(i), 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h4000, 16'hA5A5, 2'b01, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    drain();

    // Unmatched write, then clear racing a matching write.
    step(1'b1, 16'h0010, 16'h5555, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'h8002, 16'h3000 + 16'(i), 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h4000, 16'h6666, 2'b11, 1'b0, 1'b1, 1'b1);
    idle(1'b0);

    // Captures five cycles apart for timestamp spacing.
    step(1'b1, 16'h4000, 16'h7001, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (4) idle(1'b0);
    step(1'b1, 16'h4000, 16'h7002, 2'b11, 1'b0, 1'b0, 1'b0);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0: a = 16'h4000;
        1, 2: a = 16'h8000 | 16'($urandom_range(0, 3));
        3: a = 16'h8004;
        4: a = 16'h4001;
        default: a = 16'($urandom);
      endcase
      step($urandom_range(0, 9) < 6, a, 16'($urandom), 2'($urandom),
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 2);
    end
    drain();
    check_state();
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_tracer.md
Name: mem_write_tracer

Overview:
- Synthesizable, parametrised successor to the simulation-only memory write monitor.
- Passively snoops one Avalon-MM master port and matches each accepted write against NUM_WINDOWS programmable address windows.
- Keeps a saturating hit counter per window and pushes matched writes into a trace FIFO, drained through a valid/ready port.
- Sits beside the main memory port in sim and on FPGA; usable for debug readout or scoreboarding.

Parameters:
- ADDR_WIDTH, 16, word address width of the snooped port.
- DATA_WIDTH, 16, data width; multiple of 8.
- WORD_SHIFT, 2, left shift from word address to byte address; byte address width BA_W = ADDR_WIDTH+WORD_SHIFT.
- NUM_WINDOWS, 2, number of match windows, 1..8.
- WINDOW_BASE, {18'h20000, 18'h10000}, packed NUM_WINDOWS×BA_W byte base addresses; window 0 is the LSB slice.
- WINDOW_MASK, {18'h3FFF0, 18'h3FFFF}, packed NUM_WINDOWS×BA_W compare masks.
- FIFO_DEPTH, 8, trace entries; power of two, ≥2.
- COUNT_WIDTH, 16, hit/drop counter width.
- TS_WIDTH, 32, timestamp width.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- address  in  ADDR_WIDTH  snooped word address.
- byteenable  in  DATA_WIDTH/8  snooped byte enables.
- write  in  1  snooped write request.
- writedata  in  DATA_WIDTH  snooped write data.
- waitrequest  in  1  snooped slave waitrequest.
- clear  in  1  synchronous clear of counters, flags and FIFO.
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  consumer accepts head.
- trace_window  out  $clog2(NUM_WINDOWS) or 1  matched window index.
- trace_address  out  BA_W  byte address.
- trace_data  out  DATA_WIDTH  write data.
- trace_byteenable  out  DATA_WIDTH/8  byte enables.
- trace_timestamp  out  TS_WIDTH  capture cycle.
- hit_count  out  NUM_WINDOWS×COUNT_WIDTH  per-window hits; window 0 is the LSB slice.
- dropped_count  out  COUNT_WIDTH  writes lost to a full FIFO.
- overflow  out  1  sticky drop flag.
- fill_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset==0 at posedge): all outputs, counters, flags and FIFO pointers go to 0; trace_valid=0.
- Capture condition: write && !waitrequest at a posedge. No capture while reset is low.
- Byte address = {address, WORD_SHIFT'b0}.
- Window i matches when (ba & MASK[i]) == (BASE[i] & MASK[i]). The lowest matching index wins.
- An unmatched write has no effect.
- On a match, hit_count[i] increments and saturates at all-ones.
- Push: the entry holds window, ba, writedata, byteenable and timestamp.
- Latency: on an empty FIFO, trace_valid rises on the cycle after the capture edge.
- Pop: on a posedge with trace_valid && trace_ready. Head outputs are stable while trace_valid && !trace_ready.
- Full FIFO:
  - Push without pop: the entry is dropped, dropped_count increments (saturating), overflow sets.
  - Push with pop on the same edge: no drop; occupancy stays at FIFO_DEPTH.
- Empty FIFO: a pop is ignored. trace_ready has no effect while trace_valid=0.
- Pointers wrap modulo FIFO_DEPTH. fill_level ranges 0..FIFO_DEPTH.
- clear: same-edge effect as reset for counters, overflow, dropped_count and FIFO, except the timestamp counter.
  - clear beats a simultaneous capture or pop; that capture is neither counted nor stored.
- overflow clears only on reset or clear.

Optional Feature:
- Macro: MEM_WRITE_TRACER_TIMESTAMP_EN.
- Defined: a free-running TS_WIDTH counter increments every cycle from 0 after reset and wraps. The entry records its value at the capture edge.
- Undefined: no counter is built and trace_timestamp is tied to 0. The port list is unchanged.

Decomposition:
- Package mem_trace_pkg holds:
  - default constants: HEX byte address 18'h10000, PIO base 18'h20000, PIO mask 18'h3FFF0;
  - function win_idx_width(n) returning max(1, $clog2(n));
  - function fifo_lvl_width(d).
- Sub-module trace_fifo: a generic synchronous FIFO with WIDTH and DEPTH parameters.
  - Ports: push/data_in, pop/data_out, full, empty, level, flush.
  - Same-edge push and pop are allowed when full.
- The top level does window matching, counters and entry packing only.

Test Plan (defaults):
- After reset, write to word 0x4000 (ba 0x10000), data 0xBEEF, be 2'b11 -> one cycle later trace_valid=1, window=0, address=0x10000, data=0xBEEF; hit_count[0]=1.
- Write to word 0x8003 (ba 0x2000C) with waitrequest=1 for 3 cycles, then 0 -> exactly one entry, window=1; hit_count[1]=1, not 4.
- 10 window-1 writes, trace_ready=0 -> fill_level=8, dropped_count=2, overflow=1; draining 8 gives data in issue order.
- FIFO full; on the same edge a window-0 write and trace_ready=1 -> no drop, fill_level stays 8, dropped_count unchanged.
- Write to ba 0x00040 -> no entry, counters unchanged. clear asserted together with a matching write -> all counters 0, FIFO empty, overflow=0.
- With MEM_WRITE_TRACER_TIMESTAMP_EN: writes 5 cycles apart -> timestamps differ by 5. Without it: trace_timestamp=0.
